// File: rtl/rotary_enc_axi_slave.sv
// rtl/rotary_enc_axi_slave.sv - AXI4-Lite quadrature rotary encoder peripheral with bounded position counter
// Optional interrupt output is built when ROTARY_IRQ_EN is defined.
module rotary_enc_axi_slave #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 5,
    parameter int C_DEBOUNCE_CYCLES  = 1000
) (
    input  logic                              s00_axi_aclk,
    input  logic                              s00_axi_aresetn,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_awaddr,
    input  logic [2:0]                        s00_axi_awprot,
    input  logic                              s00_axi_awvalid,
    output logic                              s00_axi_awready,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_wdata,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   s00_axi_wstrb,
    input  logic                              s00_axi_wvalid,
    output logic                              s00_axi_wready,
    output logic [1:0]                        s00_axi_bresp,
    output logic                              s00_axi_bvalid,
    input  logic                              s00_axi_bready,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]     s00_axi_araddr,
    input  logic [2:0]                        s00_axi_arprot,
    input  logic                              s00_axi_arvalid,
    output logic                              s00_axi_arready,
    output logic [C_S_AXI_DATA_WIDTH-1:0]     s00_axi_rdata,
    output logic [1:0]                        s00_axi_rresp,
    output logic                              s00_axi_rvalid,
    input  logic                              s00_axi_rready,
    input  logic                              rot_a,
    input  logic                              rot_b,
    input  logic                              rot_btn,
    output logic                              irq
);
    localparam int DW  = C_S_AXI_DATA_WIDTH;
    localparam int IW  = C_S_AXI_ADDR_WIDTH - 2;
    localparam int NB  = DW / 8;
    localparam int CNW = $clog2(C_DEBOUNCE_CYCLES + 1);
`ifdef ROTARY_IRQ_EN
    localparam logic [3:0] CTRL_MASK = 4'b1111;
`else
    localparam logic [3:0] CTRL_MASK = 4'b1011;
`endif

    logic          clk;
    logic          rst_n;
    assign clk   = s00_axi_aclk;
    assign rst_n = s00_axi_aresetn;

    logic unused_ok;
    assign unused_ok = &{1'b0, s00_axi_awprot, s00_axi_arprot,
                         s00_axi_awaddr[1:0], s00_axi_araddr[1:0]};

    // ---------------- input synchroniser and debouncers ({a,b,btn})
    logic [2:0] sync1, sync2, deb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1 <= 3'b000;
            sync2 <= 3'b000;
        end else begin
            sync1 <= {rot_a, rot_b, rot_btn};
            sync2 <= sync1;
        end
    end

    for (genvar i = 0; i < 3; i++) begin : g_db
        logic [CNW-1:0] cnt;
        logic           q;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                cnt <= '0;
                q   <= 1'b0;
            end else if (sync2[i] != q) begin
                if (cnt == CNW'(C_DEBOUNCE_CYCLES - 1)) begin
                    q   <= sync2[i];
                    cnt <= '0;
                end else begin
                    cnt <= cnt + CNW'(1);
                end
            end else begin
                cnt <= '0;
            end
        end
        assign deb[i] = q;
    end

    // ---------------- registers
    logic [3:0]    ctrl;
    logic [DW-1:0] count, max_r, scratch;
    logic          st_step, st_limit;
    wire           en      = ctrl[0];
    wire           wrap    = ctrl[1];
    wire           dir_inv = ctrl[3];

    // ---------------- x1 quadrature decode
    logic [1:0] prev_ab;
    logic       prev_btn, step_up, step_dn, btn_evt;
    wire        fwd = (prev_ab == 2'b10) && (deb[2:1] == 2'b00);
    wire        rev = (prev_ab == 2'b01) && (deb[2:1] == 2'b00);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_ab  <= 2'b00;
            prev_btn <= 1'b0;
            step_up  <= 1'b0;
            step_dn  <= 1'b0;
            btn_evt  <= 1'b0;
        end else begin
            prev_ab  <= deb[2:1];
            prev_btn <= deb[0];
            step_up  <= dir_inv ? rev : fwd;
            step_dn  <= dir_inv ? fwd : rev;
            btn_evt  <= deb[0] & ~prev_btn;
        end
    end

    // ---------------- AXI write channel
    logic [IW-1:0] wr_idx;
    logic [DW-1:0] wr_data, wr_mask;
    logic [NB-1:0] wr_strb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            s00_axi_bvalid  <= 1'b0;
            wr_idx          <= '0;
            wr_data         <= '0;
            wr_strb         <= '0;
        end else begin
            s00_axi_awready <= 1'b0;
            s00_axi_wready  <= 1'b0;
            if (s00_axi_awvalid && s00_axi_wvalid && !s00_axi_bvalid && !s00_axi_awready) begin
                s00_axi_awready <= 1'b1;
                s00_axi_wready  <= 1'b1;
                wr_idx          <= s00_axi_awaddr[C_S_AXI_ADDR_WIDTH-1:2];
                wr_data         <= s00_axi_wdata;
                wr_strb         <= s00_axi_wstrb;
            end
            if (s00_axi_awready)
                s00_axi_bvalid <= 1'b1;
            else if (s00_axi_bvalid && s00_axi_bready)
                s00_axi_bvalid <= 1'b0;
        end
    end

    always_comb begin
        wr_mask = '0;
        for (int b = 0; b < NB; b++)
            wr_mask[8*b +: 8] = {8{wr_strb[b]}};
    end

    wire wr_fire  = s00_axi_awready;
    wire wr_ctrl  = wr_fire && (wr_idx == IW'(0));
    wire wr_count = wr_fire && (wr_idx == IW'(1));
    wire wr_max   = wr_fire && (wr_idx == IW'(2));
    wire wr_scr   = wr_fire && (wr_idx == IW'(3));
    wire wr_stat  = wr_fire && (wr_idx == IW'(4)) && wr_strb[0];

    // ---------------- bounded counter update
    logic [DW-1:0] next_count;
    logic          limit_hit;
    wire           applied = en && (step_up || step_dn);

    always_comb begin
        next_count = count;
        limit_hit  = 1'b0;
        if (step_up) begin
            if (count >= max_r) begin
                limit_hit  = 1'b1;
                next_count = wrap ? '0 : max_r;
            end else begin
                next_count = count + DW'(1);
            end
        end else if (step_dn) begin
            if (count == '0) begin
                limit_hit  = 1'b1;
                next_count = wrap ? max_r : '0;
            end else begin
                next_count = count - DW'(1);
            end
        end
    end

    // A COUNT write takes priority over a coincident step; the step still flags STEP.
    wire step_set  = applied | btn_evt;
    wire limit_set = applied & limit_hit & ~wr_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl     <= 4'h0;
            count    <= '0;
            max_r    <= '1;
            scratch  <= '0;
            st_step  <= 1'b0;
            st_limit <= 1'b0;
        end else begin
            if (wr_ctrl)
                ctrl <= ((ctrl & ~wr_mask[3:0]) | (wr_data[3:0] & wr_mask[3:0])) & CTRL_MASK;
            if (wr_count)
                count <= (count & ~wr_mask) | (wr_data & wr_mask);
            else if (applied)
                count <= next_count;
            if (wr_max)
                max_r <= (max_r & ~wr_mask) | (wr_data & wr_mask);
            if (wr_scr)
                scratch <= (scratch & ~wr_mask) | (wr_data & wr_mask);
            st_step  <= step_set  | (st_step  & ~(wr_stat & wr_data[1]));
            st_limit <= limit_set | (st_limit & ~(wr_stat & wr_data[2]));
        end
    end

    // ---------------- AXI read channel
    logic [IW-1:0] rd_idx;
    logic [DW-1:0] rd_mux;

    always_comb begin
        rd_mux = '0;
        case (rd_idx)
            IW'(0):  rd_mux = DW'(ctrl);
            IW'(1):  rd_mux = count;
            IW'(2):  rd_mux = max_r;
            IW'(3):  rd_mux = scratch;
            IW'(4):  rd_mux = DW'({st_limit, st_step, deb[0]});
            default: rd_mux = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s00_axi_arready <= 1'b0;
            s00_axi_rvalid  <= 1'b0;
            s00_axi_rdata   <= '0;
            rd_idx          <= '0;
        end else begin
            s00_axi_arready <= 1'b0;
            if (s00_axi_arvalid && !s00_axi_rvalid && !s00_axi_arready) begin
                s00_axi_arready <= 1'b1;
                rd_idx          <= s00_axi_araddr[C_S_AXI_ADDR_WIDTH-1:2];
            end
            if (s00_axi_arready) begin
                s00_axi_rvalid <= 1'b1;
                s00_axi_rdata  <= rd_mux;
            end else if (s00_axi_rvalid && s00_axi_rready) begin
                s00_axi_rvalid <= 1'b0;
            end
        end
    end

    assign s00_axi_bresp = 2'b00;
    assign s00_axi_rresp = 2'b00;

`ifdef ROTARY_IRQ_EN
    logic irq_q;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            irq_q <= 1'b0;
        else
            irq_q <= ctrl[2] & (st_step | st_limit);
    end
    assign irq = irq_q;
`else
    assign irq = 1'b0;
`endif

endmodule

// File: tb/tb_rotary_enc_axi_slave.sv
// tb/tb_rotary_enc_axi_slave.sv - directed self-checking bench for rotary_enc_axi_slave
module tb_rotary_enc_axi_slave;
    localparam int DB = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [4:0]  awaddr = '0, araddr = '0;
    logic [2:0]  awprot = '0, arprot = '0;
    logic        awvalid = 1'b0, wvalid = 1'b0, bready = 1'b0, arvalid = 1'b0, rready = 1'b0;
    logic [31:0] wdata = '0;
    logic [3:0]  wstrb = '0;
    logic        awready, wready, bvalid, arready, rvalid, irq;
    logic [1:0]  bresp, rresp;
    logic [31:0] rdata;
    logic        rot_a = 1'b1, rot_b = 1'b1, rot_btn = 1'b0;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    rotary_enc_axi_slave #(
        .C_S_AXI_DATA_WIDTH(32),
        .C_S_AXI_ADDR_WIDTH(5),
        .C_DEBOUNCE_CYCLES(DB)
    ) dut (
        .s00_axi_aclk(clk),       .s00_axi_aresetn(rst_n),
        .s00_axi_awaddr(awaddr),  .s00_axi_awprot(awprot),
        .s00_axi_awvalid(awvalid), .s00_axi_awready(awready),
        .s00_axi_wdata(wdata),    .s00_axi_wstrb(wstrb),
        .s00_axi_wvalid(wvalid),  .s00_axi_wready(wready),
        .s00_axi_bresp(bresp),    .s00_axi_bvalid(bvalid),
        .s00_axi_bready(bready),  .s00_axi_araddr(araddr),
        .s00_axi_arprot(arprot),  .s00_axi_arvalid(arvalid),
        .s00_axi_arready(arready), .s00_axi_rdata(rdata),
        .s00_axi_rresp(rresp),    .s00_axi_rvalid(rvalid),
        .s00_axi_rready(rready),  .rot_a(rot_a), .rot_b(rot_b),
        .rot_btn(rot_btn),        .irq(irq)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic axi_write(input logic [4:0] addr, input logic [31:0] data, input logic [3:0] strb);
        int cyc;
        awaddr = addr; wdata = data; wstrb = strb;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc = 0;
        do begin tick(1); cyc++; end while (!awready && cyc < 20);
        check("aw_latency", cyc, 1);
        check("w_ready", {31'b0, wready}, 32'd1);
        awvalid = 1'b0; wvalid = 1'b0;
        cyc = 0;
        while (!bvalid && cyc < 20) begin tick(1); cyc++; end
        check("b_latency", cyc, 1);
        check("bresp", {30'b0, bresp}, 32'd0);
        bready = 1'b1;
        tick(1);
        bready = 1'b0;
    endtask

    task automatic axi_read(input logic [4:0] addr, output logic [31:0] data);
        int cyc;
        araddr = addr; arvalid = 1'b1;
        cyc = 0;
        do begin tick(1); cyc++; end while (!arready && cyc < 20);
        check("ar_latency", cyc, 1);
        arvalid = 1'b0;
        cyc = 0;
        while (!rvalid && cyc < 20) begin tick(1); cyc++; end
        check("r_latency", cyc, 1);
        check("rresp", {30'b0, rresp}, 32'd0);
        data = rdata;
        rready = 1'b1;
        tick(1);
        rready = 1'b0;
    endtask

    task automatic rd_check(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axi_read(addr, d);
        check(tag, d, exp);
    endtask

    // One detent from the 11 rest position; each phase held well past the pin-to-count latency.
    task automatic detent(input bit cw);
        logic [1:0] seq [4];
        if (cw) seq = '{2'b10, 2'b00, 2'b01, 2'b11};
        else    seq = '{2'b01, 2'b00, 2'b10, 2'b11};
        for (int i = 0; i < 4; i++) begin
            {rot_a, rot_b} = seq[i];
            tick(12);
        end
    endtask

    initial begin
        int cyc;
        logic [31:0] exp_ctrl;

        // Reset state
        tick(2);
        check("rst_awready", {31'b0, awready}, 0);
        check("rst_wready",  {31'b0, wready},  0);
        check("rst_bvalid",  {31'b0, bvalid},  0);
        check("rst_arready", {31'b0, arready}, 0);
        check("rst_rvalid",  {31'b0, rvalid},  0);
        check("rst_rdata",   rdata, 0);
        check("rst_irq",     {31'b0, irq}, 0);
        rst_n = 1'b1;
        tick(12);
        rd_check("rst_max",    5'h08, 32'hFFFF_FFFF);
        rd_check("rst_status", 5'h10, 32'h0);

        // Register write/readback
        axi_write(5'h00, 32'h1, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        axi_write(5'h08, 32'h3, 4'hF);
        axi_write(5'h0C, 32'h4, 4'hF);
        rd_check("rb_ctrl",    5'h00, 32'h1);
        rd_check("rb_count",   5'h04, 32'h2);
        rd_check("rb_max",     5'h08, 32'h3);
        rd_check("rb_scratch", 5'h0C, 32'h4);
        axi_write(5'h0C, 32'hAABB_CCDD, 4'b0101);
        rd_check("wstrb_scratch", 5'h0C, 32'h00BB_00DD);
        axi_write(5'h14, 32'hFFFF_FFFF, 4'hF);
        rd_check("unmapped_rd", 5'h14, 32'h0);

        // Saturating CW detents
        detent(1'b1);
        rd_check("sat_cw1", 5'h04, 32'h3);
        detent(1'b1);
        rd_check("sat_cw2", 5'h04, 32'h3);
        detent(1'b1);
        rd_check("sat_cw3", 5'h04, 32'h3);
        rd_check("sat_status", 5'h10, 32'h6);
        axi_write(5'h10, 32'h6, 4'hF);
        rd_check("w1c_status", 5'h10, 32'h0);

        // Wrap on CCW underflow and CW overflow
        axi_write(5'h00, 32'h3, 4'hF);
        axi_write(5'h04, 32'h0, 4'hF);
        detent(1'b0);
        rd_check("wrap_ccw", 5'h04, 32'h3);
        rd_check("wrap_ccw_status", 5'h10, 32'h6);
        detent(1'b1);
        rd_check("wrap_cw", 5'h04, 32'h0);

        // DIR_INV: CW detent counts down
        axi_write(5'h00, 32'hB, 4'hF);
        axi_write(5'h04, 32'h2, 4'hF);
        detent(1'b1);
        rd_check("dir_inv", 5'h04, 32'h1);

        // EN=0: no count, no STEP
        axi_write(5'h00, 32'h0, 4'hF);
        axi_write(5'h10, 32'h6, 4'hF);
        detent(1'b1);
        rd_check("en_off_count",  5'h04, 32'h1);
        rd_check("en_off_status", 5'h10, 32'h0);

        // Short glitch and an invalid two-bit jump
        axi_write(5'h00, 32'h1, 4'hF);
        rot_a = 1'b0;
        tick(DB - 2);
        rot_a = 1'b1;
        tick(12);
        {rot_a, rot_b} = 2'b00;
        tick(12);
        {rot_a, rot_b} = 2'b11;
        tick(12);
        rd_check("glitch_count",  5'h04, 32'h1);
        rd_check("glitch_status", 5'h10, 32'h0);

        // Button press and interrupt
        axi_write(5'h00, 32'h5, 4'hF);
        rot_btn = 1'b1;
        tick(12);
        rd_check("btn_status", 5'h10, 32'h3);
`ifdef ROTARY_IRQ_EN
        check("irq_set", {31'b0, irq}, 32'd1);
        exp_ctrl = 32'h5;
`else
        check("irq_tied", {31'b0, irq}, 32'd0);
        exp_ctrl = 32'h1;
`endif
        axi_write(5'h10, 32'h2, 4'hF);
        check("irq_clear", {31'b0, irq}, 32'd0);
        rd_check("btn_held_status", 5'h10, 32'h1);
        rd_check("ctrl_irq_en", 5'h00, exp_ctrl);
        rot_btn = 1'b0;
        tick(12);
        rd_check("btn_release_status", 5'h10, 32'h0);

        // Reset during an outstanding write response
        axi_write(5'h0C, 32'h1234_5678, 4'hF);
        awaddr = 5'h04; wdata = 32'h2; wstrb = 4'hF;
        awvalid = 1'b1; wvalid = 1'b1;
        cyc = 0;
        while (!bvalid && cyc < 20) begin
            tick(1);
            cyc++;
            if (awready) begin awvalid = 1'b0; wvalid = 1'b0; end
        end
        check("pre_rst_bvalid", {31'b0, bvalid}, 32'd1);
        #2 rst_n = 1'b0;
        #1;
        check("rst_mid_bvalid", {31'b0, bvalid}, 32'd0);
        tick(3);
        check("rst_mid_bvalid_held", {31'b0, bvalid}, 32'd0);
        rst_n = 1'b1;
        tick(2);
        check("post_rst_bvalid", {31'b0, bvalid}, 32'd0);
        rd_check("post_rst_ctrl",    5'h00, 32'h0);
        rd_check("post_rst_count",   5'h04, 32'h0);
        rd_check("post_rst_max",     5'h08, 32'hFFFF_FFFF);
        rd_check("post_rst_scratch", 5'h0C, 32'h0);
        rd_check("post_rst_status",  5'h10, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/rotary_enc_axi_slave.md
# rotary_enc_axi_slave

AXI4-Lite slave peripheral that decodes a mechanical quadrature rotary encoder with push button into a software-visible, bounded position counter. It is the responder side of the AXI4-Lite register bus driven by the PS or VIP master, and sits inside the rotary-encoder IP between the AXI interconnect and the board encoder pins. It provides synchronisation, debouncing, x1 quadrature decode, wrap or saturate limiting, sticky event flags and an optional interrupt.

## Interface
- C_S_AXI_DATA_WIDTH, 32, bus data width (only 32 supported)
- C_S_AXI_ADDR_WIDTH, 5, byte address width; 8 word registers
- C_DEBOUNCE_CYCLES, 1000, cycles an input must be stable before acceptance (min 1)
- s00_axi_aclk  in  1  single clock for all logic
- s00_axi_aresetn  in  1  reset, asynchronous, active-low
- s00_axi_awaddr/awprot/awvalid/awready, wdata/wstrb/wvalid/wready, bresp/bvalid/bready  AXI4-Lite write channels, standard widths
- s00_axi_araddr/arprot/arvalid/arready, rdata/rresp/rvalid/rready  AXI4-Lite read channels
- rot_a, rot_b, rot_btn  in  1 each  asynchronous encoder pins
- irq  out  1  level interrupt, active-high

## Operation
- Register map, word offsets:
  - 0x00 CTRL RW: [0] EN, [1] WRAP, [2] IRQ_EN, [3] DIR_INV. Other bits read 0.
  - 0x04 COUNT RW: position; a write presets it.
  - 0x08 MAX RW: count range is 0..MAX.
  - 0x0C SCRATCH RW.
  - 0x10 STATUS: [0] BTN debounced level (RO); [1] STEP sticky (W1C); [2] LIMIT sticky (W1C).
  - 0x14–0x1C read 0; writes ignored.
- WSTRB is honoured per byte. BRESP and RRESP are always OKAY (2'b00), including for unmapped addresses. AWPROT and ARPROT are ignored.
- Input path: 2-flop synchroniser per pin, then a debouncer per pin. The debounced value updates only after the synced input differs from it for C_DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the count.
- Decode: track the previous and current debounced {a,b}.
  - CW sequence is 00→01→11→10→00. The 10→00 transition is +1; the 01→00 transition is −1.
  - DIR_INV swaps the sign.
  - All other transitions, including invalid two-bit changes, produce no step.
- Step applied only when EN=1. Every applied step sets STEP.
- +1 at COUNT≥MAX:
  - WRAP=1: COUNT becomes 0.
  - WRAP=0: COUNT holds at MAX.
  - Either case sets LIMIT.
- −1 at COUNT=0:
  - WRAP=1: COUNT becomes MAX.
  - WRAP=0: COUNT holds at 0.
  - Either case sets LIMIT.
- Writing a COUNT above MAX is stored as written. The next +1 then follows the COUNT≥MAX rule.
- A button press (debounced rising edge) sets STEP.
- Simultaneous events:
  - AXI write to COUNT and a decoded step in the same cycle: the AXI write wins and the step is dropped. STEP is still set.
  - W1C and a new set of the same bit in the same cycle: set wins.
- irq = IRQ_EN & (STEP | LIMIT), registered.

## Timing
- Reset values:
  - All ready/valid outputs 0; bresp, rresp and rdata 0; irq 0.
  - CTRL 0, COUNT 0, MAX 0xFFFFFFFF, SCRATCH 0, STATUS 0.
  - Debounced {a,b,btn} = 000; debounce counters 0.
- Reset may assert mid-transaction. All channels drop immediately and no response is issued for the aborted transaction.
- Write handshake:
  - Address and data are accepted only when AWVALID and WVALID are both high in cycle N with no BVALID outstanding.
  - AWREADY and WREADY pulse together for one cycle at N+1; the register updates at the end of N+1.
  - BVALID rises at N+2 and holds until BREADY.
- Read handshake:
  - ARVALID in cycle N with RVALID low: ARREADY pulses at N+1.
  - RDATA and RVALID are presented at N+2 and held until RREADY.
- Only one outstanding write and one outstanding read; reads and writes are independent.
- Pin-to-COUNT latency: 2 sync cycles + C_DEBOUNCE_CYCLES + 1 decode cycle + 1 update cycle. irq follows STATUS by 1 cycle.

## Configuration
- ROTARY_IRQ_EN defined:
  - irq is driven as specified.
  - CTRL[2] is implemented.
- ROTARY_IRQ_EN undefined:
  - irq is tied 0.
  - CTRL[2] is not stored and reads 0.
  - STATUS behaviour is unchanged.

## Test plan
- Reset, encoder pins held at 11. Write 1, 2, 3, 4 to 0x00/0x04/0x08/0x0C, then read back → 1, 2, 3, 4, all responses OKAY.
- CTRL=0x1, MAX=0x3, COUNT=0x2, C_DEBOUNCE_CYCLES=4. Drive 3 clean CW detents → COUNT 3, 3, 3 (saturated); STATUS reads 0x6. Write 0x6 to STATUS → reads 0x0.
- CTRL=0x3 (WRAP), MAX=0x3, COUNT=0. One CCW detent → COUNT=3 and LIMIT=1. Then one CW detent → COUNT=0.
- Glitch on rot_a shorter than C_DEBOUNCE_CYCLES, and an invalid 00→11 jump → COUNT unchanged and STATUS[1]=0.
- With ROTARY_IRQ_EN and CTRL=0x5, press rot_btn → STATUS=0x3 while held and irq=1. Clear STEP → irq=0 one cycle later. Without the macro, irq stays 0 and CTRL reads 0x1.
- Assert aresetn low during an outstanding write (BVALID high, BREADY low) → BVALID=0 immediately and all registers return to their reset values.
